hd63701_phase_seq: RTL and testbench
====================================

Name: hd63701_phase_seq

Overview:
- Phase sequencer for the HD63701 core. Generates the 6-bit PHASE and latched OPCODE that drive the microcode ROM.
- Consumes end/sleep indications decoded from the ROM's output, completing the control loop (ROM reads phase; this block writes it).
- Handles reset vectoring, opcode fetch, NMI/IRQ arbitration, sleep/wait, and the runaway-instruction limit.

Parameters:
- NOP_OPC, 8'h01, OPCODE value loaded at reset.

Ports:
- CLK  in  1  core clock.
- RST_N  in  1  synchronous reset, active low.
- DIN  in  8  opcode byte from the bus, valid in phFETCH.
- MC_END  in  1  current EXEC phase is the last of the instruction; same-cycle decode for the current PHASE.
- MC_SLEEP  in  1  qualifies MC_END; enter sleep (WAI/SLP) instead of fetch.
- NMI  in  1  non-maskable request; rising edge is sampled.
- IRQ  in  1  maskable request; level-sensitive.
- I_MASK  in  1  CCR I flag.
- PHASE  out  6  current phase.
- OPCODE  out  8  latched opcode.
- VEC_SEL  out  2  vector select: 0 RST, 1 NMI, 2 IRQ, 3 TRAP.
- FETCH  out  1  high during phFETCH.
- SLEEPING  out  1  high during phSLEEP.

Behaviour:
- Phase encodings (decided):
  - phRST=0, phVECT=1, phVEC1=2, phVEC2=3, phFETCH=4, phSLEEP=5.
  - phEXEC..phEXEC9 = 16..25.
  - phINTR..phINTR9 = 32..41.
  - Any other value is HALT.
- Reset (RST_N low at a CLK edge):
  - PHASE=phRST, OPCODE=NOP_OPC, VEC_SEL=0, FETCH=0, SLEEPING=0.
  - NMI edge register and pending flag cleared.
  - Reset mid-instruction aborts it with no further side effects.
- Reset vector path:
  - phRST -> phVECT -> phVEC1 -> phVEC2 -> phFETCH, one cycle each, unconditional.
  - VEC_SEL holds its value through phVECT..phVEC2.
- NMI detect:
  - nmi_d registers NMI every cycle.
  - nmi_pend sets on NMI & ~nmi_d.
  - nmi_pend clears in the cycle phINTR is entered with VEC_SEL=1.
  - Set and clear in the same cycle: set wins.
- Interrupt pending: int_pend = nmi_pend | (IRQ & ~I_MASK).
- phFETCH:
  - If int_pend: next phINTR; VEC_SEL=1 if nmi_pend, else 2; OPCODE unchanged.
  - Else: OPCODE<=DIN; next phEXEC.
  - FETCH=1 only in this phase.
- phEXECk, k=0..8:
  - MC_END & MC_SLEEP -> phSLEEP.
  - MC_END & ~MC_SLEEP -> phFETCH.
  - Otherwise -> phEXEC(k+1).
- phEXEC9:
  - MC_END is honoured as above.
  - Without MC_END, the instruction exceeded 10 phases; see the optional feature.
- phSLEEP:
  - SLEEPING=1; PHASE holds.
  - Leaves on int_pend: -> phINTR with VEC_SEL chosen as in phFETCH. Registers are pushed again; the single-level push model is decided.
  - IRQ masked and no NMI: stays in phSLEEP indefinitely.
- phINTR..phINTR7:
  - Advance one per cycle, then phINTR7 -> phVECT. phINTR8/9 are never issued.
  - Interrupts arriving during phINTR..phVEC2 stay pending and are re-evaluated at the next phFETCH.
- HALT encodings: an illegal PHASE value is unreachable except by fault. Next phase is phRST with VEC_SEL=0 (self-recovery).
- All outputs are registered. PHASE changes only on CLK rising edge. Decision-to-PHASE latency is 1 cycle.

Optional Feature:
- Macro: HD63701_SEQ_TRAP_EN.
- Defined: phEXEC9 with MC_END=0 goes to phINTR with VEC_SEL=3 (TRAP), and the interrupt push sequence runs. TRAP has priority over a simultaneously pending NMI/IRQ; those remain pending.
- Undefined: phEXEC9 with MC_END=0 goes to phFETCH silently, and VEC_SEL value 3 is never produced.

Test Plan:
- Reset release, MC_END tied 0 until fetch, DIN=8'h86 -> PHASE 0,1,2,3,4,16 on consecutive cycles; OPCODE=8'h86 at phEXEC; VEC_SEL=0.
- Instruction with MC_END asserted in phEXEC2 -> PHASE 16,17,18,4; FETCH high exactly one cycle.
- IRQ=1 with I_MASK=1 at phFETCH -> opcode fetched. Then I_MASK=0 at the next phFETCH -> PHASE 32..39,1,2,3,4; VEC_SEL=2; OPCODE unchanged.
- NMI pulse during phEXEC1 while IRQ=1, I_MASK=0 -> next phFETCH enters phINTR with VEC_SEL=1; nmi_pend cleared; the following phFETCH takes the IRQ (VEC_SEL=2).
- MC_END & MC_SLEEP in phEXEC0, idle 20 cycles, then NMI rising edge -> PHASE=5 with SLEEPING=1 for those cycles; then 32 the cycle after the edge is registered.
- MC_END never asserted: with TRAP_EN, phEXEC9 -> phINTR with VEC_SEL=3; without TRAP_EN, phEXEC9 -> phFETCH. Also RST_N low during phINTR3 -> PHASE=0 and OPCODE=8'h01 next cycle.

Source files
------------

// File: rtl/hd63701_phase_seq.sv
// HD63701 phase sequencer: drives PHASE/OPCODE into the microcode ROM and closes the loop on MC_END/MC_SLEEP.
// Build option: define HD63701_SEQ_TRAP_EN to vector runaway instructions (no MC_END by phEXEC9) to TRAP.
module hd63701_phase_seq #(
    parameter logic [7:0] NOP_OPC = 8'h01
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] DIN,
    input  logic       MC_END,
    input  logic       MC_SLEEP,
    input  logic       NMI,
    input  logic       IRQ,
    input  logic       I_MASK,
    output logic [5:0] PHASE,
    output logic [7:0] OPCODE,
    output logic [1:0] VEC_SEL,
    output logic       FETCH,
    output logic       SLEEPING
);

    typedef enum logic [5:0] {
        PH_RST   = 6'd0,
        PH_VECT  = 6'd1,
        PH_VEC1  = 6'd2,
        PH_VEC2  = 6'd3,
        PH_FETCH = 6'd4,
        PH_SLEEP = 6'd5,
        PH_EXEC  = 6'd16,
        PH_EXEC9 = 6'd25,
        PH_INTR  = 6'd32,
        PH_INTR7 = 6'd39,
        PH_INTR9 = 6'd41
    } phase_e;

    logic [5:0] phase_reg, phase_next;
    logic [7:0] opcode_reg, opcode_next;
    logic [1:0] vec_reg, vec_next;
    logic       nmi_d_reg, nmi_pend_reg;
    logic       fetch_reg, sleeping_reg;
    logic       nmi_clr;
    logic       int_pend;

    assign int_pend = nmi_pend_reg | (IRQ & ~I_MASK);

    always_comb begin
        phase_next  = phase_reg;
        opcode_next = opcode_reg;
        vec_next    = vec_reg;
        nmi_clr     = 1'b0;
        if (phase_reg <= PH_VEC2) begin
            // Reset/vector path is a straight count up to phFETCH.
            phase_next = phase_reg + 6'd1;
        end else if (phase_reg == PH_FETCH || phase_reg == PH_SLEEP) begin
            if (int_pend) begin
                phase_next = PH_INTR;
                vec_next   = nmi_pend_reg ? 2'd1 : 2'd2;
                nmi_clr    = nmi_pend_reg;
            end else if (phase_reg == PH_FETCH) begin
                opcode_next = DIN;
                phase_next  = PH_EXEC;
            end
        end else if (phase_reg >= PH_EXEC && phase_reg <= PH_EXEC9) begin
            if (MC_END) begin
                phase_next = MC_SLEEP ? PH_SLEEP : PH_FETCH;
            end else if (phase_reg == PH_EXEC9) begin
`ifdef HD63701_SEQ_TRAP_EN
                // Runaway instruction: TRAP outranks any pending NMI/IRQ, which stay pending.
                phase_next = PH_INTR;
                vec_next   = 2'd3;
`else
                phase_next = PH_FETCH;
`endif
            end else begin
                phase_next = phase_reg + 6'd1;
            end
        end else if (phase_reg >= PH_INTR && phase_reg < PH_INTR7) begin
            phase_next = phase_reg + 6'd1;
        end else if (phase_reg >= PH_INTR7 && phase_reg <= PH_INTR9) begin
            phase_next = PH_VECT;
        end else begin
            // Illegal encoding (HALT): recover through the reset vector.
            phase_next = PH_RST;
            vec_next   = 2'd0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            phase_reg    <= PH_RST;
            opcode_reg   <= NOP_OPC;
            vec_reg      <= 2'd0;
            nmi_d_reg    <= 1'b0;
            nmi_pend_reg <= 1'b0;
            fetch_reg    <= 1'b0;
            sleeping_reg <= 1'b0;
        end else begin
            phase_reg    <= phase_next;
            opcode_reg   <= opcode_next;
            vec_reg      <= vec_next;
            nmi_d_reg    <= NMI;
            // A new edge arriving while the old request is being taken wins over the clear.
            nmi_pend_reg <= (nmi_pend_reg & ~nmi_clr) | (NMI & ~nmi_d_reg);
            fetch_reg    <= (phase_next == PH_FETCH);
            sleeping_reg <= (phase_next == PH_SLEEP);
        end
    end

    assign PHASE    = phase_reg;
    assign OPCODE   = opcode_reg;
    assign VEC_SEL  = vec_reg;
    assign FETCH    = fetch_reg;
    assign SLEEPING = sleeping_reg;

endmodule

// File: tb/tb_hd63701_phase_seq.sv
// Self-checking bench for hd63701_phase_seq: directed scenarios with literal phases, then random stimulus
// checked every cycle against a queue-based behavioural model.
module tb_hd63701_phase_seq;

    logic       CLK = 1'b0;
    logic       RST_N, MC_END, MC_SLEEP, NMI, IRQ, I_MASK;
    logic [7:0] DIN;
    logic [5:0] PHASE;
    logic [7:0] OPCODE;
    logic [1:0] VEC_SEL;
    logic       FETCH, SLEEPING;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state
    int         m_ph;
    logic [7:0] m_opc;
    int         m_vec;
    bit         m_nmi_d, m_pend;
    bit         m_valid = 1'b0;
    int         q[$];   // phases still to be played out of a scripted sequence

    hd63701_phase_seq #(.NOP_OPC(8'h01)) dut (
        .CLK(CLK), .RST_N(RST_N), .DIN(DIN), .MC_END(MC_END), .MC_SLEEP(MC_SLEEP),
        .NMI(NMI), .IRQ(IRQ), .I_MASK(I_MASK), .PHASE(PHASE), .OPCODE(OPCODE),
        .VEC_SEL(VEC_SEL), .FETCH(FETCH), .SLEEPING(SLEEPING)
    );

    always #5 CLK = ~CLK;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Interrupt push: eight INTR phases, then the common vector fetch ending at phFETCH.
    function automatic void script_intr();
        q.delete();
        for (int p = 33; p <= 39; p++) q.push_back(p);
        for (int p = 1; p <= 4; p++) q.push_back(p);
    endfunction

    function automatic void model_step();
        int nxt;
        bit nmi_edge, clr;
        if (!RST_N) begin
            m_ph = 0; m_opc = 8'h01; m_vec = 0; m_nmi_d = 0; m_pend = 0; m_valid = 1;
            q.delete();
            for (int p = 1; p <= 4; p++) q.push_back(p);
            return;
        end
        if (!m_valid) return;
        nmi_edge = NMI && !m_nmi_d;
        m_nmi_d  = NMI;
        clr      = 0;
        nxt      = m_ph;
        if (q.size() > 0) begin
            nxt = q.pop_front();
        end else if (m_ph == 4 || m_ph == 5) begin
            if (m_pend || (IRQ && !I_MASK)) begin
                m_vec = m_pend ? 1 : 2;
                clr   = m_pend;
                nxt   = 32;
                script_intr();
            end else if (m_ph == 4) begin
                m_opc = DIN;
                nxt   = 16;
            end
        end else begin
            // Executing: instruction has used (m_ph-16)+1 phases so far.
            if (MC_END) nxt = MC_SLEEP ? 5 : 4;
            else if (m_ph - 16 < 9) nxt = m_ph + 1;
            else begin
`ifdef HD63701_SEQ_TRAP_EN
                m_vec = 3;
                nxt   = 32;
                script_intr();
`else
                nxt = 4;
`endif
            end
        end
        m_pend = (m_pend && !clr) || nmi_edge;
        m_ph   = nxt;
    endfunction

    initial forever begin
        @(posedge CLK);
        model_step();
    end

    // Every-cycle comparison against the model.
    initial forever begin
        @(negedge CLK);
        if (m_valid) begin
            chk("cyc_phase", PHASE, m_ph);
            chk("cyc_opcode", OPCODE, m_opc);
            chk("cyc_vec", VEC_SEL, m_vec);
            chk("cyc_fetch", FETCH, (m_ph == 4));
            chk("cyc_sleep", SLEEPING, (m_ph == 5));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded time limit, n_fail=%0d", n_fail);
        $fatal(1, "timeout");
    end

    task automatic lit(input int ph, input string nm);
        @(negedge CLK);
        chk({nm, "_phase"}, PHASE, ph);
        chk({nm, "_model"}, m_ph, ph);
    endtask

    task automatic lit_run(input int from, input int to, input string nm);
        for (int p = from; p <= to; p++) lit(p, nm);
    endtask

    initial begin
        RST_N = 0; DIN = 8'h86; MC_END = 0; MC_SLEEP = 0; NMI = 0; IRQ = 0; I_MASK = 1;
        repeat (3) @(negedge CLK);
        chk("rst_phase", PHASE, 0);
        chk("rst_opcode", OPCODE, 8'h01);
        chk("rst_vec", VEC_SEL, 0);
        chk("rst_fetch", FETCH, 0);
        chk("rst_sleep", SLEEPING, 0);
        RST_N = 1;

        // Reset vector then first fetch
        lit_run(1, 4, "boot");
        chk("boot_fetch", FETCH, 1);
        lit(16, "boot_exec");
        chk("boot_opcode", OPCODE, 8'h86);
        chk("boot_vec", VEC_SEL, 0);

        // MC_END in phEXEC2
        lit_run(17, 18, "end2");
        MC_END = 1;
        lit(4, "end2_fetch");
        MC_END = 0;
        chk("end2_fetch_hi", FETCH, 1);

        // Masked IRQ is ignored at fetch
        IRQ = 1; DIN = 8'h3C;
        lit(16, "mask_exec");
        chk("mask_opcode", OPCODE, 8'h3C);
        MC_END = 1; I_MASK = 0;
        lit(4, "irq_fetch");
        MC_END = 0; DIN = 8'h77;
        lit(32, "irq_intr");
        chk("irq_vec", VEC_SEL, 2);
        lit_run(33, 39, "irq_push");
        lit_run(1, 3, "irq_vect");
        chk("irq_opc_kept", OPCODE, 8'h3C);
        I_MASK = 1; DIN = 8'h5A;
        lit(4, "irq_ret");
        lit(16, "irq_next");
        chk("irq_next_opc", OPCODE, 8'h5A);

        // NMI pulse in phEXEC1 with IRQ also live
        lit(17, "nmi_exec1");
        NMI = 1; I_MASK = 0;
        lit(18, "nmi_exec2");
        NMI = 0; MC_END = 1;
        lit(4, "nmi_fetch");
        MC_END = 0;
        lit(32, "nmi_intr");
        chk("nmi_vec", VEC_SEL, 1);
        lit_run(33, 39, "nmi_push");
        lit_run(1, 4, "nmi_vect");
        lit(32, "nmi_then_irq");
        chk("nmi_then_irq_vec", VEC_SEL, 2);
        IRQ = 0;
        lit_run(33, 39, "irq2_push");
        lit_run(1, 3, "irq2_vect");
        DIN = 8'hA5;
        lit(4, "irq2_ret");
        lit(16, "irq2_exec");
        chk("irq2_opc", OPCODE, 8'hA5);

        // Sleep, masked IRQ, then NMI wake
        MC_END = 1; MC_SLEEP = 1;
        lit(5, "slp_enter");
        MC_END = 0; MC_SLEEP = 0; IRQ = 1; I_MASK = 1;
        for (int i = 0; i < 20; i++) begin
            lit(5, "slp_idle");
            chk("slp_flag", SLEEPING, 1);
        end
        NMI = 1;
        lit(5, "slp_edge");
        lit(32, "slp_wake");
        chk("slp_wake_vec", VEC_SEL, 1);
        NMI = 0; DIN = 8'h11;
        lit_run(33, 39, "slp_push");
        lit_run(1, 4, "slp_vect");
        lit(16, "slp_exec");

        // Runaway instruction: MC_END never asserted
        lit_run(17, 25, "run_exec");
`ifdef HD63701_SEQ_TRAP_EN
        lit(32, "run_trap");
        chk("run_trap_vec", VEC_SEL, 3);
        lit_run(33, 39, "trap_push");
        lit_run(1, 4, "trap_vect");
`else
        lit(4, "run_fetch");
        chk("run_vec", VEC_SEL, 1);
`endif

        // Reset during phINTR3
        I_MASK = 0;
        lit(32, "rst_intr");
        lit_run(33, 35, "rst_push");
        RST_N = 0;
        lit(0, "rst_mid");
        chk("rst_mid_opc", OPCODE, 8'h01);
        chk("rst_mid_vec", VEC_SEL, 0);
        RST_N = 1; IRQ = 0; I_MASK = 1;
        lit_run(1, 4, "rst_boot");

        // Random stimulus, checked every cycle by the compare process
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            RST_N    = ($urandom_range(0, 199) != 0);
            DIN      = 8'($urandom);
            MC_END   = ($urandom_range(0, 5) == 0);
            MC_SLEEP = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) NMI = ~NMI;
            IRQ      = ($urandom_range(0, 3) == 0);
            I_MASK   = ($urandom_range(0, 2) != 0);
        end
        @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
